// File: rtl/spi_debug_pkg.sv
// rtl/spi_debug_pkg.sv - shared FSM encoding and SPI mode constants for the debug SPI transmitter
package spi_debug_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/debug_byte_fifo.sv
// rtl/debug_byte_fifo.sv - byte FIFO for captured debug instructions with sticky overflow
module debug_byte_fifo
    import spi_debug_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] IDLE_BYTE = DEFAULT_IDLE_BYTE
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    // A pop of an empty FIFO yields IDLE_BYTE and consumes nothing; a pop frees room for a push when full.
    assign w_pop   = i_pop & ~w_empty;
    assign w_push  = i_push & (~w_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_head     = w_empty ? IDLE_BYTE : r_mem[r_rptr];
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/spi_debug_tx.sv
// rtl/spi_debug_tx.sv - SPI mode-0 slave that shifts queued debug instruction bytes out on MISO
module spi_debug_tx
    import spi_debug_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [7:0]             i_data,
    input  logic                   i_capturebyte,
    input  logic                   i_spi_clk,
    input  logic                   i_csn,
    output logic                   o_miso,
    output logic                   o_datasent,
    output logic [$clog2(DEPTH):0] o_fifo_count,
    output logic                   o_fifo_full,
    output logic                   o_overflow
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic                   r_sck_hist;
    logic [1:0]             r_state;
    logic [7:0]             r_shreg;
    logic [2:0]             r_bitcnt;
    logic                   r_reload;
    logic                   r_datasent;

    logic       w_sck;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_capture_edge;
    logic       w_launch_edge;
    logic       w_csn_low;
    logic       w_pop;
    logic [7:0] w_head;
    logic       w_empty;

    assign w_sck          = r_sck_sync[SYNC_STAGES-1];
    assign w_sck_rise     = w_sck & ~r_sck_hist;
    assign w_sck_fall     = ~w_sck & r_sck_hist;
    assign w_capture_edge = SPI_CPHA ? w_sck_fall : w_sck_rise;
    assign w_launch_edge  = SPI_CPHA ? w_sck_rise : w_sck_fall;
    assign w_csn_low      = ~r_csn_sync[SYNC_STAGES-1];
    assign w_pop          = (r_state == ST_LOAD) & w_csn_low;

    debug_byte_fifo #(
        .DEPTH     (DEPTH),
        .IDLE_BYTE (IDLE_BYTE)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (i_capturebyte),
        .i_data     (i_data),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (o_fifo_count),
        .o_full     (o_fifo_full),
        .o_empty    (w_empty),
        .o_overflow (o_overflow)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sck_sync <= {SYNC_STAGES{SPI_CPOL}};
            r_csn_sync <= {SYNC_STAGES{1'b1}};
            r_sck_hist <= SPI_CPOL;
            r_state    <= ST_IDLE;
            r_shreg    <= 8'h00;
            r_bitcnt   <= 3'd0;
            r_reload   <= 1'b0;
            r_datasent <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_clk};
            r_csn_sync <= {r_csn_sync[SYNC_STAGES-2:0], i_csn};
            r_sck_hist <= w_sck;
            r_datasent <= 1'b0;
            // Deselect wins in every state; a partly shifted byte is simply dropped.
            if (!w_csn_low) begin
                r_state  <= ST_IDLE;
                r_bitcnt <= 3'd0;
                r_reload <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        r_shreg  <= w_head;
                        r_bitcnt <= 3'd0;
                        r_state  <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_capture_edge) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_reload   <= 1'b1;
                                r_datasent <= 1'b1;
                            end
                        end
                        if (w_launch_edge) begin
                            if (r_reload) begin
                                r_reload <= 1'b0;
                                r_state  <= ST_LOAD;
                            end else begin
                                r_shreg <= {r_shreg[6:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_miso     = (r_state == ST_SHIFT) ? r_shreg[7] : 1'b0;
    assign o_datasent = r_datasent;

endmodule
